// File: rtl/uart9_rx_addr_filter.sv
// Multidrop (9th-bit address) consumer for the 9-bit UART receiver: unloads each word,
// keeps data bytes addressed to this node and queues them in a show-ahead FIFO.
//
// state | meaning
// IDLE  | waiting for the receiver to hold a word (rx_empty==0)
// ULD   | one-cycle unload strobe to the receiver
// CAPT  | rx_data is valid; evaluate address/data word
module uart9_rx_addr_filter #(
  parameter logic [7:0] BCAST_ADDR = 8'hFF,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                          rxclk,
  input  logic                          reset,
  input  logic [7:0]                    my_addr,
  input  logic                          rx_empty,
  input  logic [8:0]                    rx_data,
  output logic                          uld_rx_data,
  output logic [7:0]                    out_data,
  output logic                          out_first,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          selected,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ULD, CAPT} state_t;
  state_t state, state_nxt;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] cnt_after_pop, cnt_nxt;
  logic [8:0]    push_word, head_nxt;
  logic          capt, is_addr, addr_hit, full, pop, push_req, push;
  logic          first_pending;

  always_ff @(posedge rxclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    uld_rx_data = 1'b0;
    case (state)
      IDLE:    if (!rx_empty) state_nxt = ULD;
      ULD: begin
        uld_rx_data = 1'b1;
        state_nxt   = CAPT;
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign capt      = (state == CAPT);
  assign is_addr   = rx_data[8];
  assign addr_hit  = (rx_data[7:0] == my_addr) || (rx_data[7:0] == BCAST_ADDR);
  assign out_valid = (fifo_count != '0);
  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign push_req  = capt & ~is_addr & selected;
  assign push      = push_req & (~full | pop);
  assign push_word = {first_pending, rx_data[7:0]};

  // The head register is reloaded from the entry that will be at the head next cycle;
  // when the FIFO drains to empty before this push, the new word goes straight to the head.
  assign rd_nxt        = rd_ptr + AW'(pop);
  assign cnt_after_pop = fifo_count - CW'(pop);
  assign cnt_nxt       = cnt_after_pop + CW'(push);
  assign head_nxt      = (cnt_after_pop == '0) ? push_word : mem[rd_nxt];

  always_ff @(posedge rxclk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      out_data      <= '0;
      out_first     <= 1'b0;
      selected      <= 1'b0;
      first_pending <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_nxt;
      fifo_count <= cnt_nxt;
      if (cnt_nxt != '0) {out_first, out_data} <= head_nxt;
      if (capt && is_addr) begin
        selected      <= addr_hit;
        first_pending <= addr_hit;
      end else if (push_req) begin
        first_pending <= 1'b0;
      end
      if (push_req && !push && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart9_rx_addr_filter.sv
// Bench for uart9_rx_addr_filter: receiver model, table-driven word scenarios,
// hand-written FIFO full/reset sequences and a randomized stream against a word-level model.
module tb_uart9_rx_addr_filter;

  logic       rxclk = 1'b0;
  logic       reset;
  logic [7:0] my_addr;
  logic       rx_empty;
  logic [8:0] rx_data;
  logic       uld_rx_data;
  logic [7:0] out_data;
  logic       out_first;
  logic       out_valid;
  logic       out_ready;
  logic       selected;
  logic [3:0] fifo_count;
  logic [7:0] drop_cnt;

  uart9_rx_addr_filter #(.BCAST_ADDR(8'hFF), .FIFO_DEPTH(8)) dut (
    .rxclk(rxclk), .reset(reset), .my_addr(my_addr), .rx_empty(rx_empty), .rx_data(rx_data),
    .uld_rx_data(uld_rx_data), .out_data(out_data), .out_first(out_first), .out_valid(out_valid),
    .out_ready(out_ready), .selected(selected), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 rxclk = ~rxclk;

  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  logic [8:0] rxq[$];
  logic [8:0] got[$];
  int         uld_t[$];

  always @(posedge rxclk) cyc <= cyc + 1;

  // Receiver: hands over the head word on the edge that samples the unload strobe.
  initial begin
    logic u;
    rx_empty = 1'b1;
    rx_data  = '0;
    forever begin
      @(negedge rxclk);
      u = uld_rx_data;
      @(posedge rxclk);
      #2;
      if (u && rxq.size() > 0) rx_data = rxq.pop_front();
      rx_empty = (rxq.size() == 0);
    end
  end

  initial begin
    forever begin
      @(negedge rxclk);
      if (uld_rx_data) uld_t.push_back(cyc);
      if (out_valid && out_ready) got.push_back({out_first, out_data});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rxclk);
    #1;
  endtask

  task automatic do_reset();
    rxq.delete();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (rxq.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    chk("rx_drain_timeout", (k >= budget), 0);
    tick(6);
  endtask

  task automatic wait_uld();
    int k = 0;
    @(negedge rxclk);
    while (!uld_rx_data && k < 50) begin
      @(negedge rxclk);
      k++;
    end
    chk("uld_seen", uld_rx_data, 1);
  endtask

  typedef struct {
    logic [7:0]      addr;
    int              nw;
    logic [2:0][8:0] w;
    logic            sel;
    int              npop;
    logic [1:0][8:0] pop;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input int n, input logic [8:0] w0, w1, w2,
                              input logic s, input int np, input logic [8:0] p0, p1);
    vec_t v;
    v.addr = a; v.nw = n; v.w = {w2, w1, w0};
    v.sel = s; v.npop = np; v.pop = {p1, p0};
    return v;
  endfunction

  initial begin
    vec_t       vecs[6];
    logic [8:0] exp_q[$];
    logic [8:0] words[$];
    logic       m_sel, m_fp;
    int         zrun;

    vecs[0] = mk(8'h05, 3, 9'h105, 9'h0AA, 9'h0BB, 1'b1, 2, 9'h1AA, 9'h0BB);
    vecs[1] = mk(8'h05, 2, 9'h107, 9'h011, 9'h000, 1'b0, 0, 9'h000, 9'h000);
    vecs[2] = mk(8'h05, 2, 9'h1FF, 9'h022, 9'h000, 1'b1, 1, 9'h122, 9'h000);
    vecs[3] = mk(8'h3C, 3, 9'h13C, 9'h055, 9'h077, 1'b1, 2, 9'h155, 9'h077);
    vecs[4] = mk(8'h3C, 3, 9'h13C, 9'h1A0, 9'h066, 1'b0, 0, 9'h000, 9'h000);
    vecs[5] = mk(8'h3C, 3, 9'h105, 9'h1FF, 9'h0E1, 1'b1, 1, 9'h1E1, 9'h000);

    reset = 1'b1; my_addr = 8'h05; out_ready = 1'b1;
    tick(3);
    chk("rst_uld", uld_rx_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_first", out_first, 0);
    chk("rst_selected", selected, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    tick(1);

    for (int r = 0; r < 6; r++) begin
      my_addr = vecs[r].addr;
      got.delete(); uld_t.delete();
      for (int i = 0; i < vecs[r].nw; i++) rxq.push_back(vecs[r].w[i]);
      wait_done(100);
      chk("vec_uld_pulses", uld_t.size(), vecs[r].nw);
      for (int i = 1; i < uld_t.size(); i++) chk("vec_uld_gap", uld_t[i] - uld_t[i-1], 3);
      chk("vec_selected", selected, vecs[r].sel);
      chk("vec_npop", got.size(), vecs[r].npop);
      for (int i = 0; i < vecs[r].npop && i < got.size(); i++) chk("vec_pop", got[i], vecs[r].pop[i]);
      chk("vec_drop", drop_cnt, 0);
      chk("vec_valid_end", out_valid, 0);
    end

    // Overfill with out_ready low, then a push that meets a pop while full.
    do_reset();
    my_addr = 8'h05; out_ready = 1'b0; got.delete();
    rxq.push_back(9'h105);
    for (int i = 0; i < 10; i++) rxq.push_back(9'(8'h30 + i));
    wait_done(100);
    chk("full_count", fifo_count, 8);
    chk("full_drop", drop_cnt, 2);
    chk("full_head_data", out_data, 8'h30);
    chk("full_head_first", out_first, 1);
    tick(3);
    chk("hold_head_data", out_data, 8'h30);
    rxq.push_back(9'h0C5);
    wait_uld();
    @(posedge rxclk); #1;
    out_ready = 1'b1;
    @(posedge rxclk); #1;
    out_ready = 1'b0;
    chk("fullpush_count", fifo_count, 8);
    chk("fullpush_drop", drop_cnt, 2);
    out_ready = 1'b1;
    tick(12);
    exp_q.delete();
    exp_q.push_back(9'h130);
    for (int i = 1; i < 8; i++) exp_q.push_back(9'(8'h30 + i));
    exp_q.push_back(9'h0C5);
    chk("drain_npop", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk("drain_pop", got[i], exp_q[i]);
    chk("drain_valid", out_valid, 0);
    chk("drain_count", fifo_count, 0);
    chk("empty_hold_data", out_data, 8'hC5);
    chk("empty_hold_first", out_first, 0);

    // Reset while evaluating a data word with three entries queued.
    do_reset();
    my_addr = 8'h05; out_ready = 1'b0;
    rxq.push_back(9'h105);
    for (int i = 0; i < 4; i++) rxq.push_back(9'(8'h41 + i));
    for (int i = 0; i < 5; i++) wait_uld();
    @(posedge rxclk); #1;
    chk("capt_count", fifo_count, 3);
    reset = 1'b1;
    tick(1);
    chk("rcapt_count", fifo_count, 0);
    chk("rcapt_valid", out_valid, 0);
    chk("rcapt_selected", selected, 0);
    chk("rcapt_uld", uld_rx_data, 0);
    chk("rcapt_data", out_data, 0);
    reset = 1'b0;
    out_ready = 1'b1; got.delete();
    rxq.push_back(9'h0AB);
    wait_done(100);
    chk("rcapt_discard", got.size(), 0);
    chk("rcapt_drop", drop_cnt, 0);

    // Drop counter saturation.
    out_ready = 1'b0;
    rxq.push_back(9'h105);
    for (int i = 0; i < 268; i++) rxq.push_back(9'(i & 8'hFF));
    wait_done(2000);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_count", fifo_count, 8);

    // Randomized stream against a word-level model; out_ready never low 3 cycles running.
    do_reset();
    my_addr = 8'($urandom_range(0, 254));
    out_ready = 1'b1; got.delete(); words.delete(); exp_q.delete();
    for (int i = 0; i < 80; i++) begin
      int kind = $urandom_range(0, 7);
      logic [7:0] b = 8'($urandom_range(0, 255));
      if (kind == 0) words.push_back({1'b1, my_addr});
      else if (kind == 1) words.push_back(9'h1FF);
      else if (kind == 2) begin
        while (b == my_addr || b == 8'hFF) b = 8'($urandom_range(0, 255));
        words.push_back({1'b1, b});
      end else words.push_back({1'b0, b});
    end
    m_sel = 1'b0; m_fp = 1'b0;
    foreach (words[i]) begin
      if (words[i][8]) begin
        m_sel = (words[i][7:0] == my_addr) || (words[i][7:0] == 8'hFF);
        m_fp  = m_sel;
      end else if (m_sel) begin
        exp_q.push_back({m_fp, words[i][7:0]});
        m_fp = 1'b0;
      end
    end
    foreach (words[i]) rxq.push_back(words[i]);
    zrun = 0;
    for (int c = 0; c < 400; c++) begin
      tick(1);
      out_ready = ($urandom_range(0, 2) != 0) || (zrun >= 2);
      zrun = out_ready ? 0 : zrun + 1;
    end
    out_ready = 1'b1;
    tick(10);
    chk("rnd_rx_drained", rxq.size(), 0);
    chk("rnd_npop", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk("rnd_pop", got[i], exp_q[i]);
    chk("rnd_selected", selected, m_sel);
    chk("rnd_drop", drop_cnt, 0);
    chk("rnd_valid_end", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
